// File: rtl/store_data_unit.sv
// Store-path unit: turns rs2 store requests into lane-aligned, strobed
// data-memory write beats, splitting or rejecting boundary-crossing stores.
module store_data_unit #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [1:0]          req_size,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                store_err,
  output logic                busy
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t state, state_nx;

  logic [OW-1:0]       off;
  logic [OW-1:0]       amask;
  logic [NB-1:0]       mask;
  logic                bad_size;
  logic                err_c;
  logic [DATA_W-1:0]   dmask;
  logic [2*NB-1:0]     wide_strb;
  logic [2*DATA_W-1:0] wide_data;
  logic [DATA_W-1:0]   hi_data;
  logic [NB-1:0]       hi_strb;
  logic                split;
  logic                last;
  logic                accept;
  logic                legal;

  assign off = req_addr[OW-1:0];

  always_comb begin
    mask     = '0;
    amask    = '0;
    bad_size = 1'b0;
    unique case (req_size)
      2'b00: begin
        mask  = NB'(4'hF);
        amask = OW'(3);
      end
      2'b01: begin
        mask  = NB'(2'h3);
        amask = OW'(1);
      end
      2'b10: begin
        mask  = NB'(1'b1);
        amask = '0;
      end
      default: begin
        if (DATA_W == 64) begin
          mask  = NB'(8'hFF);
          amask = OW'(7);
        end else begin
          bad_size = 1'b1;
        end
      end
    endcase
  end

  assign err_c = bad_size
               | (!ALLOW_MISALIGNED && (|(off & amask)));

  // keep only the bytes the store size covers
  always_comb begin
    dmask = '0;
    for (int i = 0; i < NB; i++)
      dmask[8*i +: 8] = req_data[8*i +: 8] & {8{mask[i]}};
  end

  assign wide_strb = {{NB{1'b0}}, mask} << off;
  assign wide_data = {{DATA_W{1'b0}}, dmask} << {off, 3'b000};

  assign split     = |hi_strb;
  assign mem_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  assign last      = (state == BEAT1)
                   | ((state == BEAT0) & ~split);
  assign req_ready = (state == IDLE)
                   | (last & mem_valid & mem_ready);
  assign accept    = req_valid & req_ready;
  assign legal     = accept & ~err_c;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (legal) state_nx = BEAT0;
      end
      BEAT0: begin
        if (mem_ready) begin
          if (split)      state_nx = BEAT1;
          else if (legal) state_nx = BEAT0;
          else            state_nx = IDLE;
        end
      end
      BEAT1: begin
        if (mem_ready) state_nx = legal ? BEAT0 : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      hi_data   <= '0;
      hi_strb   <= '0;
      store_err <= 1'b0;
    end else begin
      store_err <= accept & err_c;
      if (legal) begin
        mem_addr  <= req_addr & ~ADDR_W'(NB - 1);
        mem_wdata <= wide_data[DATA_W-1:0];
        mem_wstrb <= wide_strb[NB-1:0];
        hi_data   <= wide_data[2*DATA_W-1:DATA_W];
        hi_strb   <= wide_strb[2*NB-1:NB];
      end else if ((state == BEAT0) && mem_ready && split) begin
        mem_addr  <= mem_addr + ADDR_W'(NB);
        mem_wdata <= hi_data;
        mem_wstrb <= hi_strb;
        hi_strb   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_store_data_unit.sv
// Bench for store_data_unit: directed cases plus random stores checked
// against a byte-by-byte reference model.
module tb_store_data_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [63:0] data;
  logic [1:0]  size;
  logic        mem_ready;
  logic        va, vb, vc;

  logic        a_rdy, a_mv, a_err, a_busy;
  logic [31:0] a_addr, a_wd;
  logic [3:0]  a_ws;
  logic        b_rdy, b_mv, b_err, b_busy;
  logic [31:0] b_addr, b_wd;
  logic [3:0]  b_ws;
  logic        c_rdy, c_mv, c_err, c_busy;
  logic [31:0] c_addr;
  logic [63:0] c_wd;
  logic [7:0]  c_ws;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  bit          stall_en = 1'b0;

  always #5 clk = ~clk;

  store_data_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(a_rdy),
    .req_addr(addr), .req_data(data[31:0]), .req_size(size),
    .mem_valid(a_mv), .mem_ready(mem_ready), .mem_addr(a_addr),
    .mem_wdata(a_wd), .mem_wstrb(a_ws), .store_err(a_err), .busy(a_busy));

  store_data_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(b_rdy),
    .req_addr(addr), .req_data(data[31:0]), .req_size(size),
    .mem_valid(b_mv), .mem_ready(mem_ready), .mem_addr(b_addr),
    .mem_wdata(b_wd), .mem_wstrb(b_ws), .store_err(b_err), .busy(b_busy));

  store_data_unit #(.DATA_W(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_c (
    .clk(clk), .rst(rst), .req_valid(vc), .req_ready(c_rdy),
    .req_addr(addr), .req_data(data), .req_size(size),
    .mem_valid(c_mv), .mem_ready(mem_ready), .mem_addr(c_addr),
    .mem_wdata(c_wd), .mem_wstrb(c_ws), .store_err(c_err), .busy(c_busy));

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: place each stored byte at its own byte address, then group by word.
  task automatic model(input logic [31:0] ad, input logic [31:0] dt,
                       input logic [1:0] sz);
    int nbytes;
    logic [31:0] base, wa, ba;
    logic [31:0] d;
    logic [3:0]  s;
    nbytes = (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = {ad[31:2], 2'b00};
    for (int b = 0; b < 2; b++) begin
      wa = base + 32'(4 * b);
      d = '0;
      s = '0;
      for (int k = 0; k < nbytes; k++) begin
        ba = ad + 32'(k);
        if ({ba[31:2], 2'b00} == wa) begin
          d[8*ba[1:0] +: 8] = dt[8*k +: 8];
          s[ba[1:0]] = 1'b1;
        end
      end
      if (s != 0) begin
        q_addr.push_back(wa);
        q_data.push_back(d);
        q_strb.push_back(s);
      end
    end
  endtask

  task automatic send_a(input logic [31:0] ad, input logic [31:0] dt,
                        input logic [1:0] sz);
    @(negedge clk);
    addr = ad;
    data = {32'h0, dt};
    size = sz;
    va = 1'b1;
    chk("send_ready", a_rdy, 1'b1);
    @(posedge clk);
    #1 va = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = budget;
    while (q_addr.size() != 0 && n > 0) begin
      @(negedge clk);
      if (a_mv) begin
        chk("beat_addr", a_addr, q_addr[0]);
        chk("beat_wdata", a_wd, q_data[0]);
        chk("beat_wstrb", a_ws, q_strb[0]);
      end
      mem_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a_mv && mem_ready) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        void'(q_strb.pop_front());
      end
      n--;
    end
    chk("drain_done", 64'(q_addr.size()), 64'd0);
    @(negedge clk);
    chk("idle_busy", a_busy, 1'b0);
    chk("idle_valid", a_mv, 1'b0);
  endtask

  task automatic err_b(input logic [31:0] ad, input logic [1:0] sz);
    @(negedge clk);
    addr = ad;
    data = 64'h0000_0000_1234_5678;
    size = sz;
    vb = 1'b1;
    chk("err_rdy0", b_rdy, 1'b1);
    @(posedge clk);
    #1 vb = 1'b0;
    @(negedge clk);
    chk("err_pulse", b_err, 1'b1);
    chk("err_novalid", b_mv, 1'b0);
    chk("err_rdy1", b_rdy, 1'b1);
    @(negedge clk);
    chk("err_once", b_err, 1'b0);
    chk("err_novalid2", b_mv, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    addr = '0; data = '0; size = '0;
    mem_ready = 1'b1;
    #12;
    chk("rst_valid", a_mv, 1'b0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_wdata", a_wd, 32'h0);
    chk("rst_wstrb", a_ws, 4'h0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_ready", a_rdy, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // word, byte, split word, address wrap
    model(32'h100, 32'hDEADBEEF, 2'b00);
    chk("t1_model", q_data[0], 32'hDEADBEEF);
    send_a(32'h100, 32'hDEADBEEF, 2'b00);
    drain(10);
    model(32'h103, 32'h123456A5, 2'b10);
    chk("t2_model", q_data[0], 32'hA5000000);
    send_a(32'h103, 32'h123456A5, 2'b10);
    drain(10);
    model(32'h102, 32'hAABBCCDD, 2'b00);
    send_a(32'h102, 32'hAABBCCDD, 2'b00);
    drain(10);
    model(32'hFFFF_FFFE, 32'h55667788, 2'b00);
    send_a(32'hFFFF_FFFE, 32'h55667788, 2'b00);
    drain(10);

    // rejected requests
    err_b(32'h103, 2'b01);
    err_b(32'h100, 2'b11);
    @(negedge clk);
    addr = 32'h100; size = 2'b11; va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    @(negedge clk);
    chk("a_sz11_err", a_err, 1'b1);
    chk("a_sz11_nov", a_mv, 1'b0);

    // stall on split beat 0, then back-to-back store on last handshake
    mem_ready = 1'b0;
    send_a(32'h102, 32'hAABBCCDD, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("st_valid", a_mv, 1'b1);
      chk("st_addr", a_addr, 32'h100);
      chk("st_wdata", a_wd, 32'hCCDD0000);
      chk("st_wstrb", a_ws, 4'b1100);
      chk("st_noready", a_rdy, 1'b0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("b1_addr", a_addr, 32'h104);
    chk("b1_wdata", a_wd, 32'h0000AABB);
    chk("b1_wstrb", a_ws, 4'b0011);
    chk("b1_ready", a_rdy, 1'b1);
    addr = 32'h200; data = 64'h11223344; size = 2'b00; va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    @(negedge clk);
    chk("b2b_valid", a_mv, 1'b1);
    chk("b2b_addr", a_addr, 32'h200);
    chk("b2b_wdata", a_wd, 32'h11223344);
    chk("b2b_wstrb", a_ws, 4'hF);
    @(negedge clk);
    chk("b2b_idle", a_busy, 1'b0);

    // reset while BEAT1 waits
    mem_ready = 1'b0;
    send_a(32'h102, 32'hAABBCCDD, 2'b00);
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("pre_rst_strb", a_ws, 4'b0011);
    #2 rst = 1'b1;
    #1 chk("rst_mid_valid", a_mv, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_nov", a_mv, 1'b0);
      chk("post_rst_rdy", a_rdy, 1'b1);
    end

    // 64-bit instance
    @(negedge clk);
    addr = 32'h8; data = 64'h0123456789ABCDEF; size = 2'b11; vc = 1'b1;
    @(posedge clk);
    #1 vc = 1'b0;
    @(negedge clk);
    chk("sd_valid", c_mv, 1'b1);
    chk("sd_addr", c_addr, 32'h8);
    chk("sd_wstrb", c_ws, 8'hFF);
    chk("sd_wdata", c_wd, 64'h0123456789ABCDEF);
    addr = 32'hC; data = 64'h0000_0000_CAFE_F00D; size = 2'b00; vc = 1'b1;
    @(posedge clk);
    #1 vc = 1'b0;
    @(negedge clk);
    chk("sw64_addr", c_addr, 32'h8);
    chk("sw64_wstrb", c_ws, 8'hF0);
    chk("sw64_wdata", c_wd, 64'hCAFE_F00D_0000_0000);

    // random stores with random stalls
    stall_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rd;
      logic [1:0]  rs;
      ra = $urandom;
      if (i % 8 == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      rd = $urandom;
      rs = 2'($urandom_range(0, 2));
      model(ra, rd, rs);
      send_a(ra, rd, rs);
      drain(80);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
